// File: rtl/dc_launch_sequencer.sv
// DC frame streamer and launch sequencer: streams a latched DC frame to the DAC
// writer, waits for DAC settling, then starts the pulse engine and tracks completion.
module dc_launch_sequencer #(
  parameter int unsigned FRAME_WORDS   = 61,
  parameter int unsigned SETTLE_CYCLES = 1000,
  parameter int unsigned DONE_TIMEOUT  = 65535
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_frame_valid,
  input  logic [4:0]                i_channel_sel,
  input  logic [FRAME_WORDS*32-1:0] i_dc_regs,
  input  logic                      i_launch_valid,
  input  logic [127:0]              i_launch_cmd,
  output logic                      o_dac_valid,
  input  logic                      i_dac_ready,
  output logic [31:0]               o_dac_word,
  output logic [4:0]                o_dac_channel,
  output logic                      o_dac_last,
  output logic                      o_launch_start,
  output logic [127:0]              o_launch_cmd,
  input  logic                      i_launch_done,
  output logic                      o_ready,
  output logic                      o_frame_drop,
  output logic                      o_launch_drop,
  output logic                      o_launch_timeout,
  output logic                      o_err_sticky
);

  localparam int unsigned IDX_W   = (FRAME_WORDS > 1) ? $clog2(FRAME_WORDS) : 1;
  localparam int unsigned CNT_MAX = (SETTLE_CYCLES > DONE_TIMEOUT) ? SETTLE_CYCLES : DONE_TIMEOUT;
  localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX + 1) : 1;

  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(FRAME_WORDS - 1);
  localparam logic [CNT_W:0]   SETTLE_LIM = (CNT_W + 1)'(SETTLE_CYCLES);
  localparam logic [CNT_W:0]   DONE_LIM   = (CNT_W + 1)'(DONE_TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE,
    S_STREAM,
    S_SETTLE,
    S_LAUNCH,
    S_WAIT_DONE
  } state_t;

  state_t                       state_q, state_d;
  logic [FRAME_WORDS-1:0][31:0] frame_q, frame_d;
  logic [4:0]                   chan_q, chan_d;
  logic [IDX_W-1:0]             idx_q, idx_d;
  logic [CNT_W-1:0]             cnt_q, cnt_d;
  logic [127:0]                 cmd_q, cmd_d;
  logic                         pending_q, pending_d;
  logic                         dirty_q, dirty_d;
  logic                         frame_drop_q, frame_drop_d;
  logic                         launch_drop_q, launch_drop_d;
  logic                         err_q, err_d;

  logic dac_valid;
  logic launch_start;
  logic timeout;
  logic settle_done;
  logic done_expire;
  logic last_beat;

  // The IDLE cycle before SETTLE counts toward the settle wait, hence the +2.
  assign settle_done = ({1'b0, cnt_q} + (CNT_W + 1)'(2)) >= SETTLE_LIM;
  assign done_expire = ({1'b0, cnt_q} + (CNT_W + 1)'(1)) >= DONE_LIM;
  assign last_beat   = (idx_q == LAST_IDX);

  always_comb begin
    state_d       = state_q;
    frame_d       = frame_q;
    chan_d        = chan_q;
    idx_d         = idx_q;
    cnt_d         = cnt_q;
    cmd_d         = cmd_q;
    pending_d     = pending_q;
    dirty_d       = dirty_q;
    frame_drop_d  = 1'b0;
    launch_drop_d = 1'b0;
    dac_valid     = 1'b0;
    launch_start  = 1'b0;
    timeout       = 1'b0;

    // Launch capture is state-independent: one command slot, extra commands are dropped.
    if (i_launch_valid) begin
      if (!pending_q) begin
        cmd_d     = i_launch_cmd;
        pending_d = 1'b1;
      end else begin
        launch_drop_d = 1'b1;
      end
    end

    if (i_frame_valid && (state_q != S_IDLE)) begin
      frame_drop_d = 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (i_frame_valid) begin
          frame_d = i_dc_regs;
          chan_d  = i_channel_sel;
          idx_d   = '0;
          state_d = S_STREAM;
        end else if (i_launch_valid || pending_q) begin
          cnt_d   = '0;
          state_d = dirty_q ? S_SETTLE : S_LAUNCH;
        end
      end
      S_STREAM: begin
        dac_valid = 1'b1;
        if (i_dac_ready) begin
          if (last_beat) begin
            dirty_d = 1'b1;
            state_d = S_IDLE;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      S_SETTLE: begin
        if (settle_done) begin
          dirty_d = 1'b0;
          state_d = S_LAUNCH;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_LAUNCH: begin
        launch_start = 1'b1;
        pending_d    = 1'b0;
        cnt_d        = '0;
        state_d      = S_WAIT_DONE;
      end
      S_WAIT_DONE: begin
        if (i_launch_done) begin
          state_d = S_IDLE;
        end else if (done_expire) begin
          timeout = 1'b1;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    err_d = err_q | frame_drop_d | launch_drop_d | timeout;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q       <= S_IDLE;
      frame_q       <= '0;
      chan_q        <= '0;
      idx_q         <= '0;
      cnt_q         <= '0;
      cmd_q         <= '0;
      pending_q     <= 1'b0;
      dirty_q       <= 1'b0;
      frame_drop_q  <= 1'b0;
      launch_drop_q <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      frame_q       <= frame_d;
      chan_q        <= chan_d;
      idx_q         <= idx_d;
      cnt_q         <= cnt_d;
      cmd_q         <= cmd_d;
      pending_q     <= pending_d;
      dirty_q       <= dirty_d;
      frame_drop_q  <= frame_drop_d;
      launch_drop_q <= launch_drop_d;
      err_q         <= err_d;
    end
  end

  assign o_dac_valid      = dac_valid;
  assign o_dac_word       = frame_q[idx_q];
  assign o_dac_channel    = chan_q;
  assign o_dac_last       = dac_valid && last_beat;
  assign o_launch_start   = launch_start;
  assign o_launch_cmd     = cmd_q;
  assign o_ready          = (state_q == S_IDLE) && !pending_q;
  assign o_frame_drop     = frame_drop_q;
  assign o_launch_drop    = launch_drop_q;
  assign o_launch_timeout = timeout;
  assign o_err_sticky     = err_q;

endmodule

// File: tb/tb_dc_launch_sequencer.sv
// Directed bench for dc_launch_sequencer with SETTLE_CYCLES=8, DONE_TIMEOUT=16.
module tb_dc_launch_sequencer;

  localparam int unsigned FW = 61;

  localparam logic [127:0] CMD1 = 128'h1111_2222_3333_4444_5555_6666_7777_0001;
  localparam logic [127:0] CMD2 = 128'hA5A5_0000_0000_0000_0000_0000_0000_0002;
  localparam logic [127:0] CMD3 = 128'hCAFE_BABE_0000_0000_0000_0000_0000_0003;
  localparam logic [127:0] CMD4 = 128'hDEAD_BEEF_0000_0000_0000_0000_0000_0004;
  localparam logic [127:0] CMD5 = 128'h0123_4567_89AB_CDEF_0000_0000_0000_0005;

  logic              clk;
  logic              rst;
  logic              frame_valid;
  logic [4:0]        channel_sel;
  logic [FW*32-1:0]  dc_regs;
  logic              launch_valid;
  logic [127:0]      launch_cmd_in;
  logic              dac_valid;
  logic              dac_ready;
  logic [31:0]       dac_word;
  logic [4:0]        dac_channel;
  logic              dac_last;
  logic              launch_start;
  logic [127:0]      launch_cmd_out;
  logic              launch_done;
  logic              ready;
  logic              frame_drop;
  logic              launch_drop;
  logic              launch_timeout;
  logic              err_sticky;

  logic [FW*32-1:0]  frame_a;
  logic [FW*32-1:0]  frame_b;

  int checks;
  int failures;

  dc_launch_sequencer #(
    .FRAME_WORDS  (FW),
    .SETTLE_CYCLES(8),
    .DONE_TIMEOUT (16)
  ) dut (
    .i_clk           (clk),
    .i_rst           (rst),
    .i_frame_valid   (frame_valid),
    .i_channel_sel   (channel_sel),
    .i_dc_regs       (dc_regs),
    .i_launch_valid  (launch_valid),
    .i_launch_cmd    (launch_cmd_in),
    .o_dac_valid     (dac_valid),
    .i_dac_ready     (dac_ready),
    .o_dac_word      (dac_word),
    .o_dac_channel   (dac_channel),
    .o_dac_last      (dac_last),
    .o_launch_start  (launch_start),
    .o_launch_cmd    (launch_cmd_out),
    .i_launch_done   (launch_done),
    .o_ready         (ready),
    .o_frame_drop    (frame_drop),
    .o_launch_drop   (launch_drop),
    .o_launch_timeout(launch_timeout),
    .o_err_sticky    (err_sticky)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs are driven and outputs sampled 1 ns after each rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_frame(input logic [FW*32-1:0] regs, input logic [4:0] ch);
    dc_regs     = regs;
    channel_sel = ch;
    frame_valid = 1'b1;
    tick();
    frame_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    checks++;
    if (dac_valid !== 1'b0) begin
      failures++; $display("FAIL reset_dac_valid got=%0b exp=0", dac_valid);
    end
    checks++;
    if (launch_cmd_out !== 128'h0) begin
      failures++; $display("FAIL reset_launch_cmd got=%0h exp=0", launch_cmd_out);
    end
    checks++;
    if ({err_sticky, frame_drop, launch_drop, launch_start, launch_timeout} !== 5'b0) begin
      failures++;
      $display("FAIL reset_pulses got=%b exp=00000",
               {err_sticky, frame_drop, launch_drop, launch_start, launch_timeout});
    end
    rst = 1'b0;
    tick();
    checks++;
    if (ready !== 1'b1) begin
      failures++; $display("FAIL reset_ready got=%0b exp=1", ready);
    end
  endtask

  task automatic test_stream_ready();
    dac_ready = 1'b1;
    start_frame(frame_a, 5'd5);
    for (int k = 0; k < FW; k++) begin
      checks++;
      if (dac_valid !== 1'b1 || dac_word !== 32'(k) || dac_channel !== 5'd5 ||
          dac_last !== (k == FW - 1)) begin
        failures++;
        $display("FAIL stream_beat%0d got v=%0b w=%0h ch=%0d l=%0b exp v=1 w=%0h ch=5 l=%0b",
                 k, dac_valid, dac_word, dac_channel, dac_last, k, (k == FW - 1));
      end
      tick();
    end
    checks++;
    if (dac_valid !== 1'b0 || ready !== 1'b1) begin
      failures++; $display("FAIL stream_end got v=%0b rdy=%0b exp v=0 rdy=1", dac_valid, ready);
    end
  endtask

  task automatic test_stream_stall();
    int exp_idx;
    logic rdy;
    exp_idx = 0;
    dac_ready = 1'b0;
    start_frame(frame_a, 5'd23);
    for (int c = 0; c < 400 && exp_idx < FW; c++) begin
      checks++;
      if (dac_valid !== 1'b1 || dac_word !== 32'(exp_idx) || dac_channel !== 5'd23 ||
          dac_last !== (exp_idx == FW - 1)) begin
        failures++;
        $display("FAIL stall_cycle%0d got v=%0b w=%0h ch=%0d l=%0b exp v=1 w=%0h ch=23 l=%0b",
                 c, dac_valid, dac_word, dac_channel, dac_last, exp_idx, (exp_idx == FW - 1));
      end
      rdy = (c % 2 == 0);
      dac_ready = rdy;
      tick();
      if (rdy) exp_idx++;
    end
    dac_ready = 1'b1;
    checks++;
    if (exp_idx != FW || dac_valid !== 1'b0) begin
      failures++; $display("FAIL stall_end got beats=%0d v=%0b exp beats=%0d v=0", exp_idx, dac_valid, FW);
    end
  endtask

  task automatic test_launch_settle();
    dac_ready = 1'b1;
    start_frame(frame_a, 5'd3);
    for (int k = 0; k < FW; k++) begin
      if (k == 10) begin
        launch_cmd_in = CMD1;
        launch_valid  = 1'b1;
      end else begin
        launch_valid = 1'b0;
      end
      if (k == 11) begin
        checks++;
        if (launch_cmd_out !== CMD1) begin
          failures++; $display("FAIL settle_cmd_latch got=%0h exp=%0h", launch_cmd_out, CMD1);
        end
      end
      checks++;
      if (ready !== 1'b0 || dac_word !== 32'(k)) begin
        failures++; $display("FAIL settle_stream%0d got rdy=%0b w=%0h exp rdy=0 w=%0h", k, ready, dac_word, k);
      end
      tick();
    end
    launch_valid = 1'b0;
    // First IDLE cycle after the stream; launch must follow 8 cycles later.
    checks++;
    if (ready !== 1'b0 || dac_valid !== 1'b0) begin
      failures++; $display("FAIL settle_reentry got rdy=%0b v=%0b exp rdy=0 v=0", ready, dac_valid);
    end
    for (int i = 1; i <= 8; i++) begin
      tick();
      checks++;
      if (launch_start !== (i == 8) || ready !== 1'b0) begin
        failures++;
        $display("FAIL settle_wait%0d got start=%0b rdy=%0b exp start=%0b rdy=0", i, launch_start, ready, (i == 8));
      end
    end
    checks++;
    if (launch_cmd_out !== CMD1) begin
      failures++; $display("FAIL settle_launch_cmd got=%0h exp=%0h", launch_cmd_out, CMD1);
    end
    tick();
    launch_done = 1'b1;
    tick();
    launch_done = 1'b0;
    checks++;
    if (ready !== 1'b1 || launch_timeout !== 1'b0) begin
      failures++; $display("FAIL settle_done got rdy=%0b to=%0b exp rdy=1 to=0", ready, launch_timeout);
    end
  endtask

  task automatic test_drops();
    int n;
    dac_ready = 1'b1;
    checks++;
    if (err_sticky !== 1'b0) begin
      failures++; $display("FAIL drops_err_pre got=%0b exp=0", err_sticky);
    end
    start_frame(frame_a, 5'd7);
    for (int k = 0; k < FW; k++) begin
      if (k == 5) begin
        dc_regs     = frame_b;
        channel_sel = 5'd1;
        frame_valid = 1'b1;
      end else begin
        frame_valid = 1'b0;
      end
      if (k == 6) begin
        checks++;
        if (frame_drop !== 1'b1 || err_sticky !== 1'b1) begin
          failures++; $display("FAIL frame_drop_pulse got drop=%0b err=%0b exp 1 1", frame_drop, err_sticky);
        end
      end
      if (k == 7) begin
        checks++;
        if (frame_drop !== 1'b0) begin
          failures++; $display("FAIL frame_drop_single got=%0b exp=0", frame_drop);
        end
      end
      checks++;
      if (dac_word !== 32'(k) || dac_channel !== 5'd7) begin
        failures++; $display("FAIL drops_beat%0d got w=%0h ch=%0d exp w=%0h ch=7", k, dac_word, dac_channel, k);
      end
      tick();
    end
    frame_valid = 1'b0;
    launch_cmd_in = CMD2;
    launch_valid  = 1'b1;
    tick();
    launch_valid = 1'b0;
    n = 0;
    while (n < 20 && launch_start !== 1'b1) begin
      tick();
      n++;
    end
    checks++;
    if (launch_start !== 1'b1 || launch_cmd_out !== CMD2) begin
      failures++; $display("FAIL drops_first_launch got start=%0b cmd=%0h exp start=1 cmd=%0h", launch_start, launch_cmd_out, CMD2);
    end
    tick();
    launch_cmd_in = CMD3;
    launch_valid  = 1'b1;
    tick();
    launch_cmd_in = CMD4;
    checks++;
    if (launch_cmd_out !== CMD3) begin
      failures++; $display("FAIL drops_pending_latch got=%0h exp=%0h", launch_cmd_out, CMD3);
    end
    tick();
    launch_valid = 1'b0;
    checks++;
    if (launch_drop !== 1'b1 || launch_cmd_out !== CMD3 || err_sticky !== 1'b1) begin
      failures++;
      $display("FAIL launch_drop_pulse got drop=%0b cmd=%0h err=%0b exp drop=1 cmd=%0h err=1", launch_drop, launch_cmd_out, err_sticky, CMD3);
    end
    tick();
    checks++;
    if (launch_drop !== 1'b0) begin
      failures++; $display("FAIL launch_drop_single got=%0b exp=0", launch_drop);
    end
    launch_done = 1'b1;
    tick();
    launch_done = 1'b0;
    checks++;
    if (ready !== 1'b0) begin
      failures++; $display("FAIL drops_pending_ready got=%0b exp=0", ready);
    end
    tick();
    checks++;
    if (launch_start !== 1'b1 || launch_cmd_out !== CMD3) begin
      failures++; $display("FAIL drops_second_launch got start=%0b cmd=%0h exp start=1 cmd=%0h", launch_start, launch_cmd_out, CMD3);
    end
    tick();
    launch_done = 1'b1;
    tick();
    launch_done = 1'b0;
    checks++;
    if (ready !== 1'b1) begin
      failures++; $display("FAIL drops_idle got=%0b exp=1", ready);
    end
  endtask

  task automatic test_timeout();
    int n;
    launch_cmd_in = CMD5;
    launch_valid  = 1'b1;
    tick();
    launch_valid = 1'b0;
    n = 0;
    while (n < 20 && launch_start !== 1'b1) begin
      tick();
      n++;
    end
    checks++;
    if (launch_start !== 1'b1 || launch_cmd_out !== CMD5) begin
      failures++; $display("FAIL timeout_launch got start=%0b cmd=%0h exp start=1 cmd=%0h", launch_start, launch_cmd_out, CMD5);
    end
    for (int i = 1; i <= 16; i++) begin
      tick();
      checks++;
      if (launch_timeout !== (i == 16)) begin
        failures++; $display("FAIL timeout_cycle%0d got=%0b exp=%0b", i, launch_timeout, (i == 16));
      end
    end
    tick();
    checks++;
    if (ready !== 1'b1 || launch_timeout !== 1'b0 || err_sticky !== 1'b1) begin
      failures++; $display("FAIL timeout_idle got rdy=%0b to=%0b err=%0b exp 1 0 1", ready, launch_timeout, err_sticky);
    end
  endtask

  task automatic test_reset_mid_stream();
    dac_ready = 1'b1;
    start_frame(frame_a, 5'd5);
    for (int k = 0; k < 30; k++) tick();
    checks++;
    if (dac_valid !== 1'b1 || dac_word !== 32'd30) begin
      failures++; $display("FAIL rst_mid_pre got v=%0b w=%0h exp v=1 w=1e", dac_valid, dac_word);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (dac_valid !== 1'b0 || dac_last !== 1'b0 || err_sticky !== 1'b0 || launch_cmd_out !== 128'h0) begin
      failures++;
      $display("FAIL rst_mid_async got v=%0b l=%0b err=%0b cmd=%0h exp 0 0 0 0", dac_valid, dac_last, err_sticky, launch_cmd_out);
    end
    tick();
    rst = 1'b0;
    tick();
    checks++;
    if (ready !== 1'b1 || dac_valid !== 1'b0) begin
      failures++; $display("FAIL rst_mid_release got rdy=%0b v=%0b exp rdy=1 v=0", ready, dac_valid);
    end
    for (int i = 0; i < 5; i++) tick();
    checks++;
    if (dac_valid !== 1'b0 || ready !== 1'b1) begin
      failures++; $display("FAIL rst_mid_no_resume got v=%0b rdy=%0b exp v=0 rdy=1", dac_valid, ready);
    end
  endtask

  initial begin
    checks        = 0;
    failures      = 0;
    rst           = 1'b1;
    frame_valid   = 1'b0;
    channel_sel   = '0;
    dc_regs       = '0;
    launch_valid  = 1'b0;
    launch_cmd_in = '0;
    dac_ready     = 1'b0;
    launch_done   = 1'b0;
    for (int k = 0; k < FW; k++) begin
      frame_a[k*32 +: 32] = 32'(k);
      frame_b[k*32 +: 32] = 32'hB000_0000 + 32'(k);
    end

    test_reset();
    test_stream_ready();
    test_stream_stall();
    test_launch_settle();
    test_drops();
    test_timeout();
    test_reset_mid_stream();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule
